// File: rtl/eth_arp_pkg.sv
// Shared state encoding and ARP constants for the ARP resolution controller.
package eth_arp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_REQ,
        WAIT_TX,
        WAIT_REPLY,
        RESOLVED,
        FAIL
    } arp_state_t;

    localparam logic        ARP_OP_REQ   = 1'b0;
    localparam logic        ARP_OP_REPLY = 1'b1;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_arp_ctrl_timer.sv
// 32-bit up-counter with clear/enable and a terminal-count flag at LIMIT-1.
module arp_timer #(
    parameter logic [31:0] LIMIT = 32'd100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 32'd1;
    end

    assign tc = (count == LIMIT - 32'd1);

endmodule

// File: rtl/eth_arp_ctrl.sv
// ARP resolver/responder sequencing one ARP transmitter.
// Optional periodic re-resolution while resolved is enabled by defining ARP_REFRESH_EN.
module eth_arp_ctrl
    import eth_arp_pkg::*;
#(
    parameter logic [31:0] DES_IP         = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [31:0] RETRY_CYCLES   = 32'd125_000_000,
    parameter logic [7:0]  MAX_TRY        = 8'd5,
    parameter logic [31:0] REFRESH_CYCLES = 32'd1_250_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        mac_valid,
    output logic [47:0] resolved_mac,
    output logic        resolve_fail,
    output logic        busy
);

    arp_state_t  state;
    logic [7:0]  try_cnt;
    logic        in_flight;
    logic        reply_pend;
    logic        got_reply;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip;

    logic tx_free;
    logic rx_req;
    logic rx_accept;
    logic retry_tc;

    // The frame finishing this cycle frees the transmitter for a launch on this edge.
    assign tx_free   = !in_flight || tx_done;
    assign rx_req    = arp_rx_done && (arp_rx_type == ARP_OP_REQ);
    assign rx_accept = arp_rx_done && (arp_rx_type == ARP_OP_REPLY) && (src_ip == DES_IP)
                       && ((state == WAIT_TX) || (state == WAIT_REPLY));

    arp_timer #(.LIMIT(RETRY_CYCLES)) u_retry (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == WAIT_TX) && tx_done),
        .en    (state == WAIT_REPLY),
        .tc    (retry_tc)
    );

`ifdef ARP_REFRESH_EN
    logic refresh_tc;

    arp_timer #(.LIMIT(REFRESH_CYCLES)) u_refresh (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != RESOLVED),
        .en    (state == RESOLVED),
        .tc    (refresh_tc)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            try_cnt      <= '0;
            in_flight    <= 1'b0;
            reply_pend   <= 1'b0;
            got_reply    <= 1'b0;
            reply_mac    <= '0;
            reply_ip     <= '0;
            arp_tx_en    <= 1'b0;
            arp_tx_type  <= ARP_OP_REQ;
            des_mac      <= BCAST_MAC;
            des_ip       <= DES_IP;
            mac_valid    <= 1'b0;
            resolved_mac <= '0;
            resolve_fail <= 1'b0;
            busy         <= 1'b0;
        end else begin
            arp_tx_en <= 1'b0;
            if (tx_done)
                in_flight <= 1'b0;

            if (rx_accept) begin
                resolved_mac <= src_mac;
                mac_valid    <= 1'b1;
            end

            // A pending reply takes the transmitter ahead of a queued request.
            if (tx_free && reply_pend) begin
                arp_tx_en   <= 1'b1;
                arp_tx_type <= ARP_OP_REPLY;
                des_mac     <= reply_mac;
                des_ip      <= reply_ip;
                in_flight   <= 1'b1;
                reply_pend  <= 1'b0;
            end

            if (rx_req) begin
                reply_pend <= 1'b1;
                reply_mac  <= src_mac;
                reply_ip   <= src_ip;
            end

            case (state)
                IDLE, RESOLVED, FAIL: begin
                    if (start) begin
                        try_cnt      <= '0;
                        mac_valid    <= 1'b0;
                        resolve_fail <= 1'b0;
                        got_reply    <= 1'b0;
                        state        <= SEND_REQ;
                        busy         <= 1'b1;
                    end
`ifdef ARP_REFRESH_EN
                    else if ((state == RESOLVED) && refresh_tc) begin
                        try_cnt <= '0;
                        state   <= SEND_REQ;
                        busy    <= 1'b1;
                    end
`endif
                end
                SEND_REQ: begin
                    if (tx_free && !reply_pend) begin
                        arp_tx_en   <= 1'b1;
                        arp_tx_type <= ARP_OP_REQ;
                        des_mac     <= BCAST_MAC;
                        des_ip      <= DES_IP;
                        in_flight   <= 1'b1;
                        try_cnt     <= try_cnt + 8'd1;
                        state       <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        got_reply <= 1'b0;
                        if (got_reply || rx_accept) begin
                            state <= RESOLVED;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_REPLY;
                        end
                    end else if (rx_accept) begin
                        got_reply <= 1'b1;
                    end
                end
                WAIT_REPLY: begin
                    if (rx_accept) begin
                        state <= RESOLVED;
                        busy  <= 1'b0;
                    end else if (retry_tc) begin
                        if (try_cnt < MAX_TRY) begin
                            state <= SEND_REQ;
                        end else begin
                            state        <= FAIL;
                            busy         <= 1'b0;
                            resolve_fail <= 1'b1;
                            mac_valid    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_arp_ctrl.sv
// Self-checking bench for eth_arp_ctrl with a 70-cycle ARP transmitter model.
// Define ARP_REFRESH_EN for both bench and RTL to exercise periodic re-resolution.
module tb_eth_arp_ctrl;

    localparam int          TX_LAT  = 70;
    localparam int          RETRY   = 100;
    localparam int          TRIES   = 3;
    localparam int          REFRESH = 1000;
    localparam logic [31:0] DES     = {8'd192, 8'd168, 8'd1, 8'd102};
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic        tx_done = 1'b0;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        mac_valid;
    logic [47:0] resolved_mac;
    logic        resolve_fail;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tx_cnt = 0;

    typedef struct {
        int          edge_n;
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } launch_t;

    launch_t launches[$];

    eth_arp_ctrl #(
        .DES_IP         (DES),
        .RETRY_CYCLES   (32'(RETRY)),
        .MAX_TRY        (8'(TRIES)),
        .REFRESH_CYCLES (32'(REFRESH))
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .arp_rx_done  (arp_rx_done),
        .arp_rx_type  (arp_rx_type),
        .src_mac      (src_mac),
        .src_ip       (src_ip),
        .tx_done      (tx_done),
        .arp_tx_en    (arp_tx_en),
        .arp_tx_type  (arp_tx_type),
        .des_mac      (des_mac),
        .des_ip       (des_ip),
        .mac_valid    (mac_valid),
        .resolved_mac (resolved_mac),
        .resolve_fail (resolve_fail),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: logs every launch and pulses tx_done in the 70th cycle after it.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            tx_cnt  = 0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt == 0)
                    tx_done = 1'b1;
            end
            if (arp_tx_en) begin
                launches.push_back('{cyc, arp_tx_type, des_mac, des_ip});
                tx_cnt = TX_LAT;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference timing: edge indices derived from launch, transmit latency and retry period.
    function automatic int done_edge(input int launch_edge);
        return launch_edge + TX_LAT + 1;
    endfunction

    function automatic int retry_launch(input int done_e);
        return done_e + RETRY + 1;
    endfunction

    function automatic launch_t launch_at(input int i);
        launch_t r;
        r.edge_n = -1;
        r.typ    = 1'bx;
        r.mac    = 'x;
        r.ip     = 'x;
        if (i < launches.size())
            r = launches[i];
        return r;
    endfunction

    function automatic logic [47:0] rand_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        arp_rx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        launches.delete();
    endtask

    task automatic start_at(input int e);
        wait_edge(e - 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rx_at(input int e, input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        wait_edge(e - 1);
        arp_rx_done = 1'b1;
        arp_rx_type = typ;
        src_mac     = mac;
        src_ip      = ip;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (arp_tx_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tx_en: got %0b expected 0", arp_tx_en); end
        n_cmp++; if (arp_tx_type !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tx_type: got %0b expected 0", arp_tx_type); end
        n_cmp++; if (des_mac !== BCAST) begin n_bad++; $display("[TB] FAIL reset_des_mac: got %h expected %h", des_mac, BCAST); end
        n_cmp++; if (des_ip !== DES) begin n_bad++; $display("[TB] FAIL reset_des_ip: got %h expected %h", des_ip, DES); end
        n_cmp++; if ({mac_valid, resolve_fail, busy} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {mac_valid, resolve_fail, busy}); end
        n_cmp++; if (resolved_mac !== 48'h0) begin n_bad++; $display("[TB] FAIL reset_resolved_mac: got %h expected 0", resolved_mac); end
    endtask

    // Reply arrives while waiting for a reply (first pass uses the reference MAC).
    task automatic test_resolve();
        for (int it = 0; it < 3; it++) begin
            int n, l1, m1, a;
            logic [47:0] mac;
            launch_t r;
            reset_dut();
            mac = (it == 0) ? 48'h0011_22AA_BBCC : rand_mac();
            n = cyc + 2;
            start_at(n);
            wait_edge(n + 1);
            l1 = n + 1;
            r = launch_at(0);
            n_cmp++; if (r.edge_n !== l1) begin n_bad++; $display("[TB] FAIL resolve_req_edge: got %0d expected %0d", r.edge_n, l1); end
            n_cmp++; if ({r.typ, r.mac, r.ip} !== {1'b0, BCAST, DES}) begin n_bad++; $display("[TB] FAIL resolve_req_frame: got %b/%h/%h expected 0/%h/%h", r.typ, r.mac, r.ip, BCAST, DES); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL resolve_busy_hi: got %0b expected 1", busy); end
            m1 = done_edge(l1);
            a = m1 + int'($urandom_range(1, RETRY - 10));
            rx_at(a, 1'b1, mac, DES);
            n_cmp++; if ({mac_valid, busy} !== 2'b10) begin n_bad++; $display("[TB] FAIL resolve_valid: got valid=%0b busy=%0b expected valid=1 busy=0", mac_valid, busy); end
            n_cmp++; if (resolved_mac !== mac) begin n_bad++; $display("[TB] FAIL resolve_mac: got %h expected %h", resolved_mac, mac); end
            wait_edge(a + 3 * RETRY);
            n_cmp++; if (launches.size() !== 1) begin n_bad++; $display("[TB] FAIL resolve_req_count: got %0d expected 1", launches.size()); end
        end
    endtask

    // Reply arrives before the request finishes transmitting.
    task automatic test_resolve_early();
        int n, l1, m1, a;
        logic [47:0] mac;
        reset_dut();
        mac = rand_mac();
        n = cyc + 2;
        start_at(n);
        l1 = n + 1;
        m1 = done_edge(l1);
        a = l1 + int'($urandom_range(3, TX_LAT - 5));
        rx_at(a, 1'b1, mac, DES);
        n_cmp++; if ({mac_valid, busy} !== 2'b11) begin n_bad++; $display("[TB] FAIL early_valid: got valid=%0b busy=%0b expected valid=1 busy=1", mac_valid, busy); end
        wait_edge(m1 - 1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL early_busy_before_done: got %0b expected 1", busy); end
        wait_edge(m1);
        n_cmp++; if ({busy, mac_valid, resolved_mac} !== {2'b01, mac}) begin n_bad++; $display("[TB] FAIL early_resolved: got busy=%0b valid=%0b mac=%h expected busy=0 valid=1 mac=%h", busy, mac_valid, resolved_mac, mac); end
    endtask

    // No acceptable reply: optional wrong-IP reply and an ignored start while busy.
    task automatic test_no_reply(input bit wrong_reply);
        int n, l[3], m[3], f;
        reset_dut();
        n = cyc + 2;
        start_at(n);
        l[0] = n + 1;
        for (int i = 0; i < 3; i++) begin
            m[i] = done_edge(l[i]);
            if (i < 2) l[i+1] = retry_launch(m[i]);
        end
        f = m[2] + RETRY;
        if (wrong_reply)
            rx_at(m[0] + 30, 1'b1, rand_mac(), {8'd192, 8'd168, 8'd1, 8'($urandom_range(0, 101))});
        start_at(m[0] + 50);
        wait_edge(f - 1);
        n_cmp++; if ({resolve_fail, busy} !== 2'b01) begin n_bad++; $display("[TB] FAIL noreply_pre_fail: got fail=%0b busy=%0b expected fail=0 busy=1", resolve_fail, busy); end
        wait_edge(f);
        n_cmp++; if ({resolve_fail, busy, mac_valid} !== 3'b100) begin n_bad++; $display("[TB] FAIL noreply_fail: got fail=%0b busy=%0b valid=%0b expected 1/0/0", resolve_fail, busy, mac_valid); end
        for (int i = 0; i < 3; i++) begin
            launch_t r;
            r = launch_at(i);
            n_cmp++; if ({r.edge_n, r.typ} !== {l[i], 1'b0}) begin n_bad++; $display("[TB] FAIL noreply_req%0d: got edge=%0d type=%b expected edge=%0d type=0", i, r.edge_n, r.typ, l[i]); end
        end
        wait_edge(f + 2 * RETRY);
        n_cmp++; if ({launches.size(), resolve_fail} !== {32'd3, 1'b1}) begin n_bad++; $display("[TB] FAIL noreply_final: got launches=%0d fail=%0b expected 3/1", launches.size(), resolve_fail); end
    endtask

    // Requests from peers: immediate reply when idle, and newest-wins while a frame is in flight.
    task automatic test_responder();
        int e, n, l1, m1;
        logic [47:0] mac_a, mac_b;
        logic [31:0] ip_a, ip_b;
        launch_t r;
        reset_dut();
        mac_a = rand_mac();
        ip_a  = $urandom;
        e = cyc + 2;
        rx_at(e, 1'b0, mac_a, ip_a);
        wait_edge(e + 1);
        r = launch_at(0);
        n_cmp++; if ({r.edge_n, r.typ, r.mac, r.ip} !== {e + 1, 1'b1, mac_a, ip_a}) begin n_bad++; $display("[TB] FAIL idle_reply: got edge=%0d type=%b %h/%h expected edge=%0d type=1 %h/%h", r.edge_n, r.typ, r.mac, r.ip, e + 1, mac_a, ip_a); end
        n = done_edge(e + 1) + 5;
        start_at(n);
        l1 = n + 1;
        m1 = done_edge(l1);
        mac_b = 48'h0A0B_0C0D_0E0F;
        ip_b  = {8'd192, 8'd168, 8'd1, 8'd7};
        rx_at(l1 + int'($urandom_range(2, 20)), 1'b0, rand_mac(), $urandom);
        rx_at(l1 + int'($urandom_range(30, 60)), 1'b0, mac_b, ip_b);
        wait_edge(m1 - 1);
        n_cmp++; if (launches.size() !== 2) begin n_bad++; $display("[TB] FAIL inflight_hold: got launches=%0d expected 2", launches.size()); end
        wait_edge(m1);
        r = launch_at(2);
        n_cmp++; if ({r.edge_n, r.typ, r.mac, r.ip} !== {m1, 1'b1, mac_b, ip_b}) begin n_bad++; $display("[TB] FAIL inflight_reply: got edge=%0d type=%b %h/%h expected edge=%0d type=1 %h/%h", r.edge_n, r.typ, r.mac, r.ip, m1, mac_b, ip_b); end
        wait_edge(m1 + 10);
        n_cmp++; if ({arp_tx_type, des_mac, des_ip} !== {1'b1, mac_b, ip_b}) begin n_bad++; $display("[TB] FAIL reply_held: got %b/%h/%h expected 1/%h/%h", arp_tx_type, des_mac, des_ip, mac_b, ip_b); end
        wait_edge(m1 + 90);
        n_cmp++; if (launches.size() !== 3) begin n_bad++; $display("[TB] FAIL single_reply: got launches=%0d expected 3", launches.size()); end
    endtask

    // start and a peer request on the same edge: reply first, request right after its tx_done.
    task automatic test_back_to_back();
        int n;
        logic [47:0] mac;
        logic [31:0] ip;
        launch_t r0, r1;
        reset_dut();
        mac = rand_mac();
        ip  = $urandom;
        n = cyc + 2;
        wait_edge(n - 1);
        start = 1'b1;
        arp_rx_done = 1'b1;
        arp_rx_type = 1'b0;
        src_mac = mac;
        src_ip  = ip;
        @(negedge clk);
        start = 1'b0;
        arp_rx_done = 1'b0;
        wait_edge(done_edge(n + 1) + 2);
        r0 = launch_at(0);
        r1 = launch_at(1);
        n_cmp++; if ({r0.edge_n, r0.typ, r0.mac, r0.ip} !== {n + 1, 1'b1, mac, ip}) begin n_bad++; $display("[TB] FAIL b2b_reply: got edge=%0d type=%b %h/%h expected edge=%0d type=1 %h/%h", r0.edge_n, r0.typ, r0.mac, r0.ip, n + 1, mac, ip); end
        n_cmp++; if ({r1.edge_n, r1.typ, r1.mac} !== {done_edge(n + 1), 1'b0, BCAST}) begin n_bad++; $display("[TB] FAIL b2b_request: got edge=%0d type=%b mac=%h expected edge=%0d type=0 mac=%h", r1.edge_n, r1.typ, r1.mac, done_edge(n + 1), BCAST); end
    endtask

    // One-cycle reset while waiting for a reply with a reply frame in flight.
    task automatic test_reset_mid();
        int n, l1, m1, rr;
        reset_dut();
        n = cyc + 2;
        start_at(n);
        l1 = n + 1;
        m1 = done_edge(l1);
        rx_at(l1 + 20, 1'b0, rand_mac(), $urandom);
        rr = m1 + 20;
        wait_edge(rr - 1);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({arp_tx_en, arp_tx_type, mac_valid, resolve_fail, busy} !== 5'b0) begin n_bad++; $display("[TB] FAIL midreset_flags: got %b expected 00000", {arp_tx_en, arp_tx_type, mac_valid, resolve_fail, busy}); end
        n_cmp++; if ({des_mac, des_ip, resolved_mac} !== {BCAST, DES, 48'h0}) begin n_bad++; $display("[TB] FAIL midreset_regs: got %h/%h/%h expected %h/%h/0", des_mac, des_ip, resolved_mac, BCAST, DES); end
        rst_n = 1'b1;
        wait_edge(rr + 600);
        n_cmp++; if (launches.size() !== 2) begin n_bad++; $display("[TB] FAIL midreset_quiet: got launches=%0d expected 2", launches.size()); end
    endtask

`ifdef ARP_REFRESH_EN
    // Periodic re-resolution keeps the old MAC valid until refresh retries run out.
    task automatic test_refresh();
        int n, a, l[3], m[3], f;
        logic [47:0] mac;
        launch_t r;
        reset_dut();
        mac = rand_mac();
        n = cyc + 2;
        start_at(n);
        a = done_edge(n + 1) + 10;
        rx_at(a, 1'b1, mac, DES);
        l[0] = a + REFRESH + 1;
        for (int i = 0; i < 3; i++) begin
            m[i] = done_edge(l[i]);
            if (i < 2) l[i+1] = retry_launch(m[i]);
        end
        f = m[2] + RETRY;
        wait_edge(l[0]);
        r = launch_at(1);
        n_cmp++; if ({r.edge_n, r.typ, mac_valid, resolved_mac} !== {l[0], 1'b0, 1'b1, mac}) begin n_bad++; $display("[TB] FAIL refresh_req: got edge=%0d type=%b valid=%0b mac=%h expected edge=%0d type=0 valid=1 mac=%h", r.edge_n, r.typ, mac_valid, resolved_mac, l[0], mac); end
        wait_edge(f - 1);
        n_cmp++; if ({mac_valid, resolve_fail, launches.size()} !== {2'b10, 32'd4}) begin n_bad++; $display("[TB] FAIL refresh_pre_fail: got valid=%0b fail=%0b launches=%0d expected 1/0/4", mac_valid, resolve_fail, launches.size()); end
        wait_edge(f);
        n_cmp++; if ({mac_valid, resolve_fail, busy} !== 3'b010) begin n_bad++; $display("[TB] FAIL refresh_fail: got valid=%0b fail=%0b busy=%0b expected 0/1/0", mac_valid, resolve_fail, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_resolve();
        test_resolve_early();
        test_no_reply(1'b0);
        test_no_reply(1'b1);
        test_responder();
        test_back_to_back();
        test_reset_mid();
`ifdef ARP_REFRESH_EN
        test_refresh();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
